// File: rtl/clk_mux_n_pkg.sv
// clk_mux_n_pkg: shared FSM states, selector width helper and default constants for clk_mux_n.
package clk_mux_n_pkg;

    typedef enum logic [1:0] {BOOT, IDLE, DISABLE, ENABLE} state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_CYC_DEF = 1024;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_mux_chan.sv
// clk_mux_chan: one source channel; enable resynchronised on the source's falling edge,
// AND-gated with the source, and the effective enable acknowledged back into clk0.
module clk_mux_chan #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_src,
    input  logic clk0,
    input  logic rst,
    input  logic en_req,
    output logic g,
    output logic ack
);
    logic [SYNC_STAGES-1:0] en_sync, ack_sync;

    // enable only moves while the source is low, so the gate never cuts a high phase
    always_ff @(negedge clk_src or negedge rst)
        if (!rst) en_sync <= '0;
        else en_sync <= {en_sync[SYNC_STAGES-2:0], en_req};

    assign g = en_sync[SYNC_STAGES-1] & clk_src;

    always_ff @(posedge clk0 or negedge rst)
        if (!rst) ack_sync <= '0;
        else ack_sync <= {ack_sync[SYNC_STAGES-2:0], en_sync[SYNC_STAGES-1]};

    assign ack = ack_sync[SYNC_STAGES-1];
endmodule

// File: rtl/clk_mux_n.sv
// clk_mux_n: NUM_CLK-input glitch-free clock mux switched by a clk0-domain request/busy handshake.
// Define CLK_MUX_N_TIMEOUT_EN to bound each handshake phase to TIMEOUT_CYC clk0 cycles.
module clk_mux_n
    import clk_mux_n_pkg::*;
#(
    parameter int NUM_CLK     = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEFAULT_SEL = 0,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                          clk0,
    input  logic                          rst,
    input  logic [NUM_CLK-1:0]            clk_src,
    input  logic [sel_width(NUM_CLK)-1:0] sel,
    input  logic                          sel_req,
    output logic                          busy,
    output logic                          locked,
    output logic [sel_width(NUM_CLK)-1:0] cur_sel,
    output logic                          err,
    output logic                          clk_out
);
    localparam int SW = sel_width(NUM_CLK);
    // one bit per encodable selector value, set where that value names a real source
    localparam logic [(1<<SW)-1:0] LEGAL = {(1<<SW){1'b1}} >> ((1<<SW) - NUM_CLK);

    if (NUM_CLK < 2 || NUM_CLK > 16 || SYNC_STAGES < 2 || TIMEOUT_CYC < 1 ||
        DEFAULT_SEL < 0 || DEFAULT_SEL >= NUM_CLK) begin : g_bad_cfg
        $error("clk_mux_n: illegal parameter set");
    end

    state_t             state, state_nxt;
    logic [SW-1:0]      tgt, tgt_nxt, cur_sel_nxt;
    logic [NUM_CLK-1:0] en_req, en_req_nxt, g, ack;
    logic               locked_nxt, err_nxt;
    logic               dis_to, en_to;

`ifdef CLK_MUX_N_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    // restarts on every state change so each handshake phase gets a full budget
    always_ff @(posedge clk0 or negedge rst)
        if (!rst) cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else if (state == DISABLE || state == ENABLE) cnt <= cnt + 1'b1;

    assign dis_to = (state == DISABLE) && (cnt == CW'(TIMEOUT_CYC - 1));
    assign en_to  = (state == ENABLE) && (cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign dis_to = 1'b0;
    assign en_to  = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        tgt_nxt     = tgt;
        cur_sel_nxt = cur_sel;
        en_req_nxt  = en_req;
        locked_nxt  = locked;
        err_nxt     = err;
        case (state)
            BOOT: begin
                tgt_nxt                 = SW'(DEFAULT_SEL);
                cur_sel_nxt             = SW'(DEFAULT_SEL);
                en_req_nxt              = '0;
                en_req_nxt[DEFAULT_SEL] = 1'b1;
                state_nxt               = ENABLE;
            end
            IDLE: if (sel_req) begin
                if (!LEGAL[sel]) err_nxt = 1'b1;
                else if (sel != cur_sel) begin
                    tgt_nxt    = sel;
                    en_req_nxt = '0;
                    state_nxt  = DISABLE;
                end
            end
            DISABLE: if (!ack[cur_sel] || dis_to) begin
                en_req_nxt      = '0;
                en_req_nxt[tgt] = 1'b1;
                cur_sel_nxt     = tgt;
                locked_nxt      = 1'b0;
                err_nxt         = err | dis_to;
                state_nxt       = ENABLE;
            end
            ENABLE: if (ack[tgt]) begin
                locked_nxt = 1'b1;
                state_nxt  = IDLE;
            end else if (en_to) begin
                err_nxt    = 1'b1;
                locked_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst)
        if (!rst) begin
            state   <= BOOT;
            tgt     <= SW'(DEFAULT_SEL);
            cur_sel <= SW'(DEFAULT_SEL);
            en_req  <= '0;
            locked  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            tgt     <= tgt_nxt;
            cur_sel <= cur_sel_nxt;
            en_req  <= en_req_nxt;
            locked  <= locked_nxt;
            err     <= err_nxt;
        end

    assign busy = (state != IDLE);

    for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
        clk_mux_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
            .clk_src(clk_src[i]),
            .clk0   (clk0),
            .rst    (rst),
            .en_req (en_req[i]),
            .g      (g[i]),
            .ack    (ack[i])
        );
    end

    assign clk_out = |g;
endmodule

// File: tb/tb_clk_mux_n.sv
// tb_clk_mux_n: scoreboard bench for clk_mux_n; one time unit is 0.5 ns so every half-period is an integer.
module tb_clk_mux_n;
    logic       clk0 = 1'b0, rst = 1'b0, sel_req = 1'b0;
    logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, hold3 = 1'b0;
    logic [3:0] clk_src;
    logic [1:0] sel = 2'd0, cur_sel, watch = 2'd0;
    logic       busy, locked, err, clk_out, wsrc;
    logic       glitch_en = 1'b0, busy_q = 1'b1;
    int         n_cmp = 0, n_bad = 0;
    time        last_t = 0, min_ph = 1000;

    typedef struct packed {logic [1:0] cs; logic lk; logic er;} exp_t;
    exp_t q[$];
    exp_t e;

    assign clk_src = {s3, s2, s1, s0};
    assign wsrc = clk_src[watch];

    always #10 clk0 = ~clk0;
    always #10 s0 = ~s0;
    always #13 s1 = ~s1;
    always #27 s2 = ~s2;
    always #40 s3 = hold3 ? 1'b0 : ~s3;

    clk_mux_n #(.NUM_CLK(4), .SYNC_STAGES(2), .DEFAULT_SEL(0), .TIMEOUT_CYC(64)) dut (
        .clk0   (clk0),
        .rst    (rst),
        .clk_src(clk_src),
        .sel    (sel),
        .sel_req(sel_req),
        .busy   (busy),
        .locked (locked),
        .cur_sel(cur_sel),
        .err    (err),
        .clk_out(clk_out)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // every completed switch (busy falling) is matched against the next queued expectation
    always @(posedge clk0) begin
        #2;
        if (busy_q && busy === 1'b0 && rst) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_done: cur_sel %0d with nothing expected", cur_sel);
            end else begin
                e = q.pop_front();
                check("sb_cur_sel", 32'(cur_sel), 32'(e.cs));
                check("sb_locked", 32'(locked), 32'(e.lk));
                check("sb_err", 32'(err), 32'(e.er));
            end
        end
        busy_q = busy;
    end

    // shortest clk_out phase seen (in units of 0.5 ns) while runt checking is enabled
    always @(clk_out) begin
        if (glitch_en && last_t != 0 && $time - last_t < min_ph) min_ph = $time - last_t;
        last_t = $time;
    end

    task automatic request(input logic [1:0] s);
        @(negedge clk0);
        sel = s;
        sel_req = 1'b1;
        @(negedge clk0);
        sel_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int k = 0;
        while (busy !== 1'b0 && k < lim) begin
            @(negedge clk0);
            k++;
        end
        check(nm, 32'(busy), 32'd0);
    endtask

    task automatic follow(input logic [1:0] idx, input string nm);
        watch = idx;
        #1;
        repeat (3) begin
            @(posedge wsrc);
            #2;
            check({nm, "_hi"}, 32'(clk_out), 32'd1);
            @(negedge wsrc);
            #2;
            check({nm, "_lo"}, 32'(clk_out), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_cur_sel", 32'(cur_sel), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        q.push_back({2'd0, 1'b1, 1'b0});
        rst = 1'b1;
        wait_idle("boot_lock_12", 12);
        check("boot_locked", 32'(locked), 32'd1);
        glitch_en = 1'b1;
        follow(2'd0, "follow0");

        q.push_back({2'd2, 1'b1, 1'b0});
        request(2'd2);
        check("sw2_busy", 32'(busy), 32'd1);
        wait_idle("sw2_done", 100);
        follow(2'd2, "follow2");

        request(2'd2);
        check("same_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk0);
        check("same_busy_late", 32'(busy), 32'd0);
        follow(2'd2, "follow2_same");

        q.push_back({2'd0, 1'b1, 1'b0});
        request(2'd0);
        request(2'd3);
        check("ign_busy", 32'(busy), 32'd1);
        wait_idle("sw0_done", 100);
        q.push_back({2'd1, 1'b1, 1'b0});
        request(2'd1);
        wait_idle("sw1_done", 100);
        check("final_sel1", 32'(cur_sel), 32'd1);
        follow(2'd1, "follow1");

        glitch_en = 1'b0;
        request(2'd3);
        check("dis_busy", 32'(busy), 32'd1);
        watch = 2'd1;
        #1;
        @(posedge wsrc);
        #2;
        check("pre_rst_clk", 32'(clk_out), 32'd1);
        rst = 1'b0;
        #2;
        check("rst_clk_low", 32'(clk_out), 32'd0);
        check("rst_busy2", 32'(busy), 32'd1);
        check("rst_cur_sel2", 32'(cur_sel), 32'd0);
        q.push_back({2'd0, 1'b1, 1'b0});
        repeat (2) @(negedge clk0);
        rst = 1'b1;
        wait_idle("recover", 20);
        glitch_en = 1'b1;
        follow(2'd0, "follow0_rec");

`ifdef CLK_MUX_N_TIMEOUT_EN
        hold3 = 1'b1;
        repeat (6) @(negedge clk0);
        q.push_back({2'd3, 1'b0, 1'b1});
        request(2'd3);
        wait_idle("to_done", 200);
        check("to_err", 32'(err), 32'd1);
        check("to_locked", 32'(locked), 32'd0);
`endif

        repeat (3) @(negedge clk0);
        check("sb_drain", 32'(q.size()), 32'd0);
        check("min_phase_ok", 32'(min_ph >= 10), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
